// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port unified memory between the multi-cycle core
//   (port 0) and the debug/loader port (port 1), one transaction at a time.
//   Requests are sampled only in IDLE. The memory returns read data LAT cycles
//   after the issue cycle. Every output is driven directly from a flop.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : round robin when both ports request;
//                                   the port that did not own the last
//                                   transaction wins.
//                       undefined : fixed priority; the core wins.
//
// Parameters: AW address width, DW data width, LAT read latency (LAT >= 1).
//
// Ports:
//   clk, rst                         clock and async active-high reset
//   c_req/c_we/c_addr/c_wdata        core request           (in)
//   c_gnt/c_done/c_rdata             core grant/done/read data (out)
//   d_req/d_we/d_addr/d_wdata        loader request         (in)
//   d_gnt/d_done/d_rdata             loader grant/done/read data (out)
//   m_en/m_we/m_addr/m_wdata         memory command         (out)
//   m_rdata                          memory read data       (in)
//   busy                             transaction in flight  (out)
//
// State  | meaning
// IDLE   | sample requests, pick a winner
// ISSUE  | drive the memory command for one cycle, grant the winner
// WAIT   | LAT cycles for read data; captured on the last one
// RESP   | one-cycle done pulse to the winner
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_done,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  if (LAT < 1) begin : g_lat_chk
    $fatal(1, "mem_arbiter: LAT must be at least 1");
  end

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          winner_q, winner_d;   // 0 = core, 1 = loader
  logic          we_q, we_d;
  logic          pick;
  logic          c_gnt_q, c_gnt_d, d_gnt_q, d_gnt_d;
  logic          c_done_q, c_done_d, d_done_q, d_done_d;
  logic          m_en_q, m_en_d, m_we_q, m_we_d, busy_q, busy_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;
  assign pick = (c_req && d_req) ? ~last_owner_q : d_req;
`else
  assign pick = ~c_req;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    winner_d  = winner_q;
    we_d      = we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          state_d   = ISSUE;
          winner_d  = pick;
          we_d      = pick ? d_we    : c_we;
          m_addr_d  = pick ? d_addr  : c_addr;
          m_wdata_d = pick ? d_wdata : c_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_owner_d = pick;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CW'(LAT - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (!we_q) begin
            if (winner_q) d_rdata_d = m_rdata;
            else          c_rdata_d = m_rdata;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered
    // in the same cycle as the state they belong to.
    m_en_d   = (state_d == ISSUE);
    m_we_d   = (state_d == ISSUE) && we_d;
    c_gnt_d  = (state_d == ISSUE) && !winner_d;
    d_gnt_d  = (state_d == ISSUE) &&  winner_d;
    c_done_d = (state_d == RESP)  && !winner_d;
    d_done_d = (state_d == RESP)  &&  winner_d;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      winner_q  <= 1'b0;
      we_q      <= 1'b0;
      c_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      c_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      busy_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      winner_q  <= winner_d;
      we_q      <= we_d;
      c_gnt_q   <= c_gnt_d;
      d_gnt_q   <= d_gnt_d;
      c_done_q  <= c_done_d;
      d_done_q  <= d_done_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      busy_q    <= busy_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign c_gnt   = c_gnt_q;
  assign d_gnt   = d_gnt_q;
  assign c_done  = c_done_q;
  assign d_done  = d_done_q;
  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;
  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
  logic        c_gnt, c_done, d_gnt, d_done, m_en, m_we, busy;
  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [31:0] rd_addr = 0;

  // Extra instances for the LAT=1 and LAT=4 latency checks.
  logic        l1_req = 0, l4_req = 0;
  logic        l1_cg, l1_cd, l1_dg, l1_dd, l1_en, l1_we, l1_busy;
  logic        l4_cg, l4_cd, l4_dg, l4_dd, l4_en, l4_we, l4_busy;
  logic [31:0] l1_cr, l1_dr, l1_ma, l1_mw, l4_cr, l4_dr, l4_ma, l4_mw;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ((a ^ 32'hA5A5_0000) + 32'h1);
  endfunction

  // Memory model: read data for the last issued address.
  always @(posedge clk) if (m_en) rd_addr <= m_addr;
  assign m_rdata = mem_val(rd_addr);

  mem_arbiter #(.AW(32), .DW(32), .LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy));

  mem_arbiter #(.AW(32), .DW(32), .LAT(1)) u_l1 (
    .clk(clk), .rst(rst),
    .c_req(l1_req), .c_we(1'b0), .c_addr(32'h8), .c_wdata(32'h0),
    .c_gnt(l1_cg), .c_done(l1_cd), .c_rdata(l1_cr),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_gnt(l1_dg), .d_done(l1_dd), .d_rdata(l1_dr),
    .m_en(l1_en), .m_we(l1_we), .m_addr(l1_ma), .m_wdata(l1_mw),
    .m_rdata(32'h0000_1111), .busy(l1_busy));

  mem_arbiter #(.AW(32), .DW(32), .LAT(4)) u_l4 (
    .clk(clk), .rst(rst),
    .c_req(l4_req), .c_we(1'b0), .c_addr(32'h8), .c_wdata(32'h0),
    .c_gnt(l4_cg), .c_done(l4_cd), .c_rdata(l4_cr),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_gnt(l4_dg), .d_done(l4_dd), .d_rdata(l4_dr),
    .m_en(l4_en), .m_we(l4_we), .m_addr(l4_ma), .m_wdata(l4_mw),
    .m_rdata(32'h0000_4444), .busy(l4_busy));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  // Grants and dones never overlap across ports.
  always @(negedge clk)
    if (!rst) check("excl", {62'b0, c_gnt & d_gnt, c_done & d_done}, 64'h0);

  logic g[4];
  int   ng;
  int   cd_seen;
  int   t1, t4;

  initial begin
    do_reset();
    check("rst_gnt",   {c_gnt, d_gnt, c_done, d_done}, 0);
    check("rst_mem",   {m_en, m_we, busy}, 0);
    check("rst_maddr", m_addr, 0);
    check("rst_mwd",   m_wdata, 0);
    check("rst_crd",   c_rdata, 0);
    check("rst_drd",   d_rdata, 0);

    // Core read 0x10, LAT=2.
    c_req = 1; c_we = 0; c_addr = 32'h10;
    tick();                                     // T+1
    c_req = 0;
    check("rd_gnt",   c_gnt, 1);
    check("rd_dgnt",  d_gnt, 0);
    check("rd_men",   m_en, 1);
    check("rd_mwe",   m_we, 0);
    check("rd_maddr", m_addr, 32'h10);
    check("rd_busy1", busy, 1);
    tick();                                     // T+2
    check("rd_men2",  m_en, 0);
    check("rd_gnt2",  c_gnt, 0);
    check("rd_busy2", busy, 1);
    check("rd_done2", c_done, 0);
    tick();                                     // T+3
    check("rd_done3", c_done, 0);
    check("rd_busy3", busy, 1);
    tick();                                     // T+4
    check("rd_done4", c_done, 1);
    check("rd_data",  c_rdata, 32'hDEADBEEF);
    check("rd_busy4", busy, 1);
    tick();                                     // T+5
    check("rd_done5", c_done, 0);
    check("rd_busy5", busy, 0);
    check("rd_hold",  c_rdata, 32'hDEADBEEF);

    // Loader write 0x20.
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
    tick();
    d_req = 0; d_we = 0;
    check("wr_gnt",   d_gnt, 1);
    check("wr_cgnt",  c_gnt, 0);
    check("wr_mwe",   m_we, 1);
    check("wr_maddr", m_addr, 32'h20);
    check("wr_mwd",   m_wdata, 32'h12345678);
    tick(); tick(); tick();
    check("wr_done",  d_done, 1);
    check("wr_drd",   d_rdata, 0);
    check("wr_crd",   c_rdata, 32'hDEADBEEF);
    tick();
    check("wr_idle",  busy, 0);

    // Both ports requesting continuously from reset.
    do_reset();
    c_req = 1; d_req = 1; c_addr = 32'h50; d_addr = 32'h60;
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      tick();
      if (c_gnt || d_gnt) begin
        g[ng] = d_gnt;
        ng++;
      end
    end
    c_req = 0; d_req = 0;
    check("arb_cnt", ng, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      check($sformatf("arb_rr%0d", i), g[i], i % 2);
`else
      check($sformatf("arb_fp%0d", i), g[i], 0);
`endif
    end
    wait_idle("arb_idle");

    // Loader request arriving while the core is in WAIT is held off.
    c_req = 1; c_we = 0; c_addr = 32'h30;
    tick();                                     // ISSUE
    c_req = 0;
    check("ho_cgnt", c_gnt, 1);
    tick();                                     // WAIT 1
    d_req = 1; d_we = 0; d_addr = 32'h10;
    tick();                                     // WAIT 2
    check("ho_dgnt_w", d_gnt, 0);
    tick();                                     // RESP
    check("ho_cdone", c_done, 1);
    check("ho_dgnt_r", d_gnt, 0);
    check("ho_crd", c_rdata, mem_val(32'h30));
    tick();                                     // IDLE
    check("ho_idle", busy, 0);
    check("ho_dgnt_i", d_gnt, 0);
    tick();                                     // loader ISSUE
    d_req = 0;
    check("ho_dgnt", d_gnt, 1);
    check("ho_maddr", m_addr, 32'h10);
    tick(); tick(); tick();
    check("ho_ddone", d_done, 1);
    check("ho_drd", d_rdata, 32'hDEADBEEF);
    wait_idle("ho_end");

    // Reset in the middle of a core read.
    c_req = 1; c_addr = 32'h40;
    tick();                                     // ISSUE
    c_req = 0;
    tick();                                     // WAIT 1
    #2 rst = 1'b1;
    #1;
    check("ar_ctl", {c_gnt, d_gnt, c_done, d_done, m_en, m_we, busy}, 0);
    check("ar_addr", m_addr, 0);
    check("ar_crd", c_rdata, 0);
    check("ar_drd", d_rdata, 0);
    @(posedge clk); #1 rst = 1'b0;
    cd_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (c_done) cd_seen++;
    end
    check("ar_nodone", cd_seen, 0);
    c_req = 1; c_addr = 32'h40;
    tick();
    c_req = 0;
    check("ar_gnt", c_gnt, 1);
    tick(); tick(); tick();
    check("ar_done", c_done, 1);
    check("ar_crd2", c_rdata, mem_val(32'h40));
    wait_idle("ar_end");

    // LAT=1 and LAT=4 instances: done offset from the sample cycle.
    l1_req = 1; l4_req = 1;
    t1 = -1; t4 = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        l1_req = 0; l4_req = 0;
      end
      if (l1_cd && t1 < 0) t1 = k;
      if (l4_cd && t4 < 0) t4 = k;
    end
    check("lat1_done", t1, 3);
    check("lat4_done", t4, 6);
    check("lat1_data", l1_cr, 32'h0000_1111);
    check("lat4_data", l4_cr, 32'h0000_4444);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
